// File: rtl/window_3x3_scanner.sv
// rtl/window_3x3_scanner.sv - 3x3 sliding-window scanner over three captured padded rows
//
// Captures three padded rows on a rows_valid pulse and presents one 3x3 window per
// column under a valid/ready handshake, then pulses conv_done (and frame_done on the
// last row set of a frame).
//
// Ports:
//   clk          - sole clock, rising edge
//   resetn       - synchronous reset, active high (1 resets the block)
//   row_1..row_3 - top/middle/bottom padded rows, W+2 elements of D*DATA_BITS each
//   rows_valid   - one-cycle pulse qualifying row_1..row_3
//   window       - 3x3 window, slot 3*r+k = row r, column col+k; zero outside SCAN
//   window_valid - window holds valid data (state is SCAN)
//   window_ready - downstream accepts the window
//   col          - column index of the current window
//   conv_done    - one-cycle pulse after the last window of a row set is accepted
//   frame_done   - conv_done of the H-th row set
//   overrun      - sticky: rows_valid arrived while not IDLE
module window_3x3_scanner #(
   parameter int DATA_BITS = 8,
   parameter int D         = 1,
   parameter int W         = 24,
   parameter int H         = 24
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [D*(W+2)*DATA_BITS-1:0]    row_1,
   input  logic [D*(W+2)*DATA_BITS-1:0]    row_2,
   input  logic [D*(W+2)*DATA_BITS-1:0]    row_3,
   input  logic                            rows_valid,
   output logic [9*D*DATA_BITS-1:0]        window,
   output logic                            window_valid,
   input  logic                            window_ready,
   output logic [$clog2(W)-1:0]            col,
   output logic                            conv_done,
   output logic                            frame_done,
   output logic                            overrun
);

   localparam int EW  = D * DATA_BITS;
   localparam int RW  = D * (W + 2) * DATA_BITS;
   localparam int CW  = $clog2(W);
   localparam int RCW = (H > 1) ? $clog2(H) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [RW-1:0]  rows_q [3];
   logic [RCW-1:0] row_cnt_q;
   logic           accept;
   logic           last_col;

   assign window_valid = (state_q == SCAN);
   assign accept       = window_valid && window_ready;
   assign last_col     = (col == CW'(W - 1));
   assign conv_done    = (state_q == DONE);
   assign frame_done   = (state_q == DONE) && (row_cnt_q == RCW'(H - 1));

   // State register
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; DONE always lasts exactly one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rows_valid) state_d = SCAN;
         SCAN:    if (accept && last_col) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Captured rows, column, row counter and overrun flag
   always_ff @(posedge clk) begin
      if (resetn) begin
         rows_q[0] <= '0;
         rows_q[1] <= '0;
         rows_q[2] <= '0;
         col       <= '0;
         row_cnt_q <= '0;
         overrun   <= 1'b0;
      end else begin
         if (rows_valid && state_q == IDLE) begin
            rows_q[0] <= row_1;
            rows_q[1] <= row_2;
            rows_q[2] <= row_3;
            col       <= '0;
         end
         if (accept) begin
            col <= last_col ? '0 : col + CW'(1);
         end
         if (state_q == DONE) begin
            row_cnt_q <= (row_cnt_q == RCW'(H - 1)) ? '0 : row_cnt_q + RCW'(1);
         end
         // Rows arriving mid-scan are dropped; the flag tells software data was lost
         if (rows_valid && state_q != IDLE) begin
            overrun <= 1'b1;
         end
      end
   end

   // Window mux: elements col, col+1, col+2 of each captured row
   always_comb begin
      window = '0;
      if (state_q == SCAN) begin
         for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) begin
               window[EW*(3*r+k) +: EW] = rows_q[r][EW*(int'(col)+k) +: EW];
            end
         end
      end
   end

endmodule

// File: tb/tb_window_3x3_scanner.sv
// tb/tb_window_3x3_scanner.sv - directed self-checking bench for window_3x3_scanner
module tb_window_3x3_scanner;

   localparam int DB = 8;
   localparam int W  = 24;
   localparam int H  = 24;
   localparam int RW = (W + 2) * DB;

   logic          clk = 1'b0;
   logic          resetn;
   logic [RW-1:0] row_1, row_2, row_3;
   logic          rows_valid;
   logic [71:0]   window;
   logic          window_valid;
   logic          window_ready;
   logic [4:0]    col;
   logic          conv_done;
   logic          frame_done;
   logic          overrun;

   int passed = 0;
   int total  = 0;

   window_3x3_scanner #(.DATA_BITS(DB), .D(1), .W(W), .H(H)) dut (
      .clk(clk), .resetn(resetn),
      .row_1(row_1), .row_2(row_2), .row_3(row_3),
      .rows_valid(rows_valid),
      .window(window), .window_valid(window_valid), .window_ready(window_ready),
      .col(col), .conv_done(conv_done), .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Slot 3r+k holds element col+k of row r, whose value is col+k+1+32*r
   function automatic logic [71:0] exp_win(input int c);
      logic [71:0] w;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int k = 0; k < 3; k++)
            w[DB*(3*r+k) +: DB] = 8'(c + k + 1 + 32*r);
      return w;
   endfunction

   task automatic load_rows();
      for (int e = 0; e < W + 2; e++) begin
         row_1[DB*e +: DB] = 8'(e + 1);
         row_2[DB*e +: DB] = 8'(e + 33);
         row_3[DB*e +: DB] = 8'(e + 65);
      end
   endtask

   // From IDLE: pulse rows_valid and check the first window one cycle later
   task automatic start_set(input string tag);
      rows_valid = 1'b1;
      step();
      rows_valid = 1'b0;
      chk({tag, "_valid"}, 128'(window_valid), 128'd1);
      chk({tag, "_col0"},  128'(col), 128'd0);
   endtask

   // With ready held high, scan until conv_done (bounded) and check the DONE cycle
   task automatic run_to_done(input string tag, input logic exp_frame);
      window_ready = 1'b1;
      for (int i = 0; i < 40 && !conv_done; i++) step();
      chk({tag, "_conv_done"},  128'(conv_done), 128'd1);
      chk({tag, "_frame_done"}, 128'(frame_done), 128'(exp_frame));
      chk({tag, "_win_zero"},   128'(window), 128'd0);
   endtask

   initial begin
      resetn       = 1'b1;
      rows_valid   = 1'b0;
      window_ready = 1'b0;
      row_1 = '0; row_2 = '0; row_3 = '0;
      step();
      step();
      chk("rst_valid", 128'(window_valid), 128'd0);
      chk("rst_col",   128'(col), 128'd0);
      chk("rst_conv",  128'(conv_done), 128'd0);
      chk("rst_frame", 128'(frame_done), 128'd0);
      chk("rst_ovr",   128'(overrun), 128'd0);
      chk("rst_win",   128'(window), 128'd0);

      // Full scan with ready held high
      resetn = 1'b0;
      load_rows();
      window_ready = 1'b1;
      start_set("s1");
      chk("s1_win0", 128'(window), 128'(exp_win(0)));
      for (int c = 0; c < W; c++) begin
         chk($sformatf("s1_col%0d", c), 128'(col), 128'(c));
         chk($sformatf("s1_win%0d", c), 128'(window), 128'(exp_win(c)));
         chk($sformatf("s1_nodone%0d", c), 128'(conv_done), 128'd0);
         step();
      end
      chk("s1_conv_done", 128'(conv_done), 128'd1);
      chk("s1_frame",     128'(frame_done), 128'd0);
      chk("s1_done_nv",   128'(window_valid), 128'd0);
      step();
      chk("s1_conv_1cyc", 128'(conv_done), 128'd0);
      chk("s1_idle_nv",   128'(window_valid), 128'd0);

      // Ready pattern 1,0,0,1
      start_set("s2");
      window_ready = 1'b1;
      step();
      chk("s2_col_a", 128'(col), 128'd1);
      window_ready = 1'b0;
      step();
      chk("s2_col_b", 128'(col), 128'd1);
      chk("s2_win_b", 128'(window), 128'(exp_win(1)));
      step();
      chk("s2_col_c", 128'(col), 128'd1);
      chk("s2_win_c", 128'(window), 128'(exp_win(1)));
      chk("s2_vld_c", 128'(window_valid), 128'd1);
      window_ready = 1'b1;
      step();
      chk("s2_col_d", 128'(col), 128'd2);
      chk("s2_win_d", 128'(window), 128'(exp_win(2)));
      run_to_done("s2", 1'b0);

      // rows_valid in the IDLE cycle right after conv_done
      step();
      start_set("s3");
      chk("s3_no_ovr", 128'(overrun), 128'd0);
      chk("s3_win0",   128'(window), 128'(exp_win(0)));
      run_to_done("s3", 1'b0);
      step();

      // Mid-scan rows_valid at col=5 with different data
      start_set("s4");
      for (int i = 0; i < 5; i++) step();
      chk("s4_col5", 128'(col), 128'd5);
      window_ready = 1'b0;
      row_1 = '1; row_2 = '1; row_3 = '1;
      rows_valid = 1'b1;
      step();
      rows_valid = 1'b0;
      load_rows();
      chk("s4_ovr",  128'(overrun), 128'd1);
      chk("s4_col",  128'(col), 128'd5);
      chk("s4_win",  128'(window), 128'(exp_win(5)));
      window_ready = 1'b1;
      step();
      chk("s4_win6", 128'(window), 128'(exp_win(6)));
      run_to_done("s4", 1'b0);
      chk("s4_ovr_sticky", 128'(overrun), 128'd1);
      step();

      // Reset at col=10 mid-scan
      start_set("s5");
      for (int i = 0; i < 10; i++) step();
      chk("s5_col10", 128'(col), 128'd10);
      resetn = 1'b1;
      step();
      resetn = 1'b0;
      chk("s5_rst_valid", 128'(window_valid), 128'd0);
      chk("s5_rst_col",   128'(col), 128'd0);
      chk("s5_rst_conv",  128'(conv_done), 128'd0);
      chk("s5_rst_ovr",   128'(overrun), 128'd0);
      step();
      chk("s5_no_conv",   128'(conv_done), 128'd0);
      load_rows();
      start_set("s5r");
      chk("s5r_win0", 128'(window), 128'(exp_win(0)));
      run_to_done("f1", 1'b0);
      step();

      // Frame: sets 2..25 after reset; frame_done only on the 24th
      for (int n = 2; n <= 25; n++) begin
         start_set($sformatf("f%0d", n));
         run_to_done($sformatf("f%0d", n), (n == 24));
         step();
      end
      chk("end_ovr", 128'(overrun), 128'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
